// File: rtl/wishbone_slave.sv
// Wishbone responder backed by a word-addressed 32-bit memory bank.
// Optional wait states: define WB_SLAVE_WAIT_EN.
module wishbone_slave #(
   parameter int unsigned DEPTH       = 256,
   parameter logic [1:0]  SEL_MATCH   = 2'b11,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic        we_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic [1:0]  sel_i,
   output logic [31:0] data_o,
   output logic        ack_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK  = 2'd1
`ifdef WB_SLAVE_WAIT_EN
      ,
      S_WAIT = 2'd2
`endif
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   data_q, data_d;
   logic [AW-1:0] idx;
   logic          capture;
   logic          wr_en;
   logic          unused_bits;

`ifdef WB_SLAVE_WAIT_EN
   logic [3:0]    cnt_q, cnt_d;
`endif

   assign idx     = addr_i[AW+1:2];
   assign capture = (state_q == S_IDLE) && cyc_i && stb_i
                    && (sel_i == SEL_MATCH);
   // Gate with reset so a write cannot slip in while held in reset.
   assign wr_en   = capture && we_i && rst_ni;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
`ifdef WB_SLAVE_WAIT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (capture) begin
               data_d = we_i ? 32'd0 : mem[idx];
`ifdef WB_SLAVE_WAIT_EN
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end else begin
                  state_d = S_ACK;
               end
`else
               state_d = S_ACK;
`endif
            end
         end
         S_ACK: begin
            state_d = S_IDLE;
            data_d  = 32'd0;
         end
`ifdef WB_SLAVE_WAIT_EN
         S_WAIT: begin
            if (!cyc_i) begin
               state_d = S_IDLE;
               data_d  = 32'd0;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd0) begin
               state_d = S_ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
            data_d  = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         data_q  <= 32'd0;
`ifdef WB_SLAVE_WAIT_EN
         cnt_q   <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
`ifdef WB_SLAVE_WAIT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Memory is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem[idx] <= data_i;
   end

   assign data_o = data_q;
   assign ack_o  = (state_q == S_ACK);

   assign unused_bits = (^{addr_i[31:AW+2], addr_i[1:0]})
                        ^ (WAIT_CYCLES != 0);

endmodule

// File: doc/wishbone_slave.md
# wishbone_slave

Wishbone responder for the processor's single-transfer Wishbone master, backed by a word-addressed 32-bit register/RAM bank. It sits on the data-side bus next to the data memory or peripheral decode. It captures each request during the master's one-cycle strobe and answers with a one-cycle `ack_o` while the master holds `cyc` with `stb` low. It serves as the data-memory endpoint and as the template responder for peripherals.

## Interface
Parameters:
- `DEPTH`, 256 — number of 32-bit words; power of two, 2..4096.
- `SEL_MATCH`, 2'b11 — `sel_i` value this slave answers to (2'b11 = data memory; device slots use `addr[17:16]` codes).
- `WAIT_CYCLES`, 2 — extra wait states before `ack_o`; range 0..15; only used with `WB_SLAVE_WAIT_EN`.

Ports:
- `clk_i`  in  1  — single clock, all logic on rising edge.
- `rst_ni`  in  1  — reset, asynchronous, active-low.
- `addr_i`  in  32  — byte address; word index = `addr_i[$clog2(DEPTH)+1:2]`.
- `data_i`  in  32  — write data (master `data_o`).
- `we_i`  in  1  — 1 = write, 0 = read.
- `cyc_i`  in  1  — bus cycle active.
- `stb_i`  in  1  — request strobe, high exactly one cycle per transfer.
- `sel_i`  in  2  — device select.
- `data_o`  out  32  — read data, valid while `ack_o`=1.
- `ack_o`  out  1  — transfer acknowledge, registered.

## Operation
- Memory: `DEPTH` x 32 bit register array, not reset; contents are X until first written.
- Request capture: in IDLE, `cyc_i & stb_i & (sel_i == SEL_MATCH)` at a rising edge latches word index, `we_i`, and `data_i`.
  - Writes commit to memory on that same edge.
  - Reads latch `mem[index]` into `data_o` on that same edge.
- Non-matching `sel_i`, or `stb_i` without `cyc_i`: ignored; state stays IDLE.
- Address bits above the index and `addr_i[1:0]` are ignored. Out-of-range addresses alias (wrap modulo `DEPTH`).
- FSM states:
  - IDLE → ACK on capture (no waits), or IDLE → WAIT on capture (waits enabled and `WAIT_CYCLES`>0; counter loaded with `WAIT_CYCLES`-1).
  - WAIT: counter decrements each cycle; when it is 0, go to ACK. If `cyc_i`=0, go to IDLE.
  - ACK: `ack_o`=1 for exactly one cycle, then IDLE unconditionally.
- `ack_o` is 1 only in ACK. `data_o` holds the read word through ACK. `data_o` is 0 for writes, and returns to 0 on leaving ACK.
- `stb_i` seen in WAIT/ACK (protocol violation): ignored, not queued.
- Abort: `cyc_i` low in WAIT discards the read. An already-committed write stays committed. No ack is issued.
- Reset (any time, including mid-transfer): state IDLE, `ack_o`=0, `data_o`=0, wait counter 0. Memory unchanged.

## Timing
- Edge E0: master raises `cyc`/`stb`.
- Edge E1: capture and write commit.
- Without waits, `ack_o` is high in the cycle after E1, while master `stb`=0 and `cyc`=1. The master samples `data_o` at E2, and `ack_o` falls at E2.
- Latency E0 → ack cycle = 1 cycle + N wait states.
- Back-to-back: a new capture is possible from the first IDLE cycle after ACK. This matches the master, which is busy until `cyc` drops.
- Reset is asynchronous on assertion. Deassertion is synchronised externally; the first capture occurs no earlier than the first edge after release.

## Configuration
- `WB_SLAVE_WAIT_EN` defined: WAIT state and 4-bit counter are compiled in, and ack arrives `WAIT_CYCLES` cycles after the zero-wait timing. `WAIT_CYCLES`=0 behaves as zero-wait.
- Not defined: WAIT state and counter are absent, `WAIT_CYCLES` is ignored, and ACK always follows capture directly.

## Test plan
- Write `addr`=0x0000_0010, `data`=0xDEAD_BEEF, `sel`=2'b11, then read the same address → read `ack_o` one cycle after `stb`, `data_o`=0xDEAD_BEEF.
- Read with `sel_i`=2'b01 (≠ `SEL_MATCH`) and `cyc` held 5 cycles → `ack_o` stays 0, `data_o`=0.
- `DEPTH`=256: write 0x1234_5678 to 0x0000_0400, then read 0x0000_0000 → 0x1234_5678 (wrap).
- `WB_SLAVE_WAIT_EN` with `WAIT_CYCLES`=3: read → `ack_o` exactly 4 cycles after the `stb` cycle and high for 1 cycle. Drop `cyc` during WAIT on a second read → no ack, FSM back in IDLE.
- Assert `rst_ni`=0 in ACK cycle → `ack_o` and `data_o` go to 0 immediately (asynchronously). A previously written word still reads back after release.
- Ten back-to-back master write/read pairs with random data → every read matches the last write, and exactly one `ack_o` per `stb`.
